// File: rtl/mask_pkg.sv
// Shared definitions for the mask frame statistics block: default widths,
// the frame FSM state type and the empty bounding-box initial values.
package mask_pkg;

    localparam int X_W_DEF    = 10;
    localparam int AREA_W_DEF = 20;
    localparam int RUN_W_DEF  = 16;

    // Frame sequencing states
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACCUM     = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    // An empty box starts inverted so the first mask pixel sets both edges
    localparam logic [31:0] BOX_MIN_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] BOX_MAX_INIT = 32'h0000_0000;

endpackage

// File: rtl/mask_run_detector.sv
// Horizontal run-start detector for the registered pixel stream.
// Remembers the previous accepted pixel's mask and row and flags a mask=1
// pixel that opens a new run (previous pixel was 0, new row, column 0, or
// first pixel of a frame).
module mask_run_detector
    import mask_pkg::*;
#(
    parameter int X_W = X_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sync_clear,
    input  logic           frame_first,
    input  logic           pix_en,
    input  logic           mask,
    input  logic [X_W-1:0] tv_x,
    input  logic [X_W-1:0] tv_y,
    output logic           run_start
);

    logic           prev_mask;
    logic [X_W-1:0] prev_y;

    // Previous-pixel memory; forgotten outside a frame and at every frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mask <= 1'b0;
            prev_y    <= '0;
        end else if (sync_clear) begin
            prev_mask <= 1'b0;
        end else if (frame_first) begin
            prev_mask <= pix_en & mask;
            if (pix_en) begin
                prev_y <= tv_y;
            end
        end else if (pix_en) begin
            prev_mask <= mask;
            prev_y    <= tv_y;
        end
    end

    // A set pixel starts a run unless it directly continues one on the same row
    always_comb begin
        run_start = pix_en && mask &&
                    (frame_first || !prev_mask || (tv_y != prev_y) || (tv_x == '0));
    end

endmodule

// File: rtl/mask_frame_stats.sv
// Per-frame statistics over the binary pixel mask: area, bounding box and
// horizontal run count, presented on a valid/ready port at each frame end.
// Optional feature macro: MASK_FRAME_STATS_RUNS_EN compiles in the run
// detector and counter; without it stat_runs is constant zero.
module mask_frame_stats
    import mask_pkg::*;
#(
    parameter int X_W    = X_W_DEF,
    parameter int AREA_W = AREA_W_DEF,
    parameter int RUN_W  = RUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic              mask,
    input  logic [X_W-1:0]    tv_x,
    input  logic [X_W-1:0]    tv_y,
    output logic              stat_valid,
    input  logic              stat_ready,
    output logic [AREA_W-1:0] stat_area,
    output logic [X_W-1:0]    stat_x_min,
    output logic [X_W-1:0]    stat_x_max,
    output logic [X_W-1:0]    stat_y_min,
    output logic [X_W-1:0]    stat_y_max,
    output logic [RUN_W-1:0]  stat_runs,
    output logic              stat_empty,
    output logic              stat_overrun
);

    localparam logic [X_W-1:0] MIN_INIT = BOX_MIN_INIT[X_W-1:0];
    localparam logic [X_W-1:0] MAX_INIT = BOX_MAX_INIT[X_W-1:0];

    state_t state;
    state_t state_next;

    logic           pix_en_r;
    logic           mask_r;
    logic [X_W-1:0] x_r;
    logic [X_W-1:0] y_r;

    logic [AREA_W-1:0] area_acc;
    logic [X_W-1:0]    x_min_acc;
    logic [X_W-1:0]    x_max_acc;
    logic [X_W-1:0]    y_min_acc;
    logic [X_W-1:0]    y_max_acc;

    logic [AREA_W-1:0] area_nxt;
    logic [X_W-1:0]    x_min_nxt;
    logic [X_W-1:0]    x_max_nxt;
    logic [X_W-1:0]    y_min_nxt;
    logic [X_W-1:0]    y_max_nxt;

    logic [AREA_W-1:0] base_area;
    logic [X_W-1:0]    base_x_min;
    logic [X_W-1:0]    base_x_max;
    logic [X_W-1:0]    base_y_min;
    logic [X_W-1:0]    base_y_max;

    logic count_en;
    logic latch;
    logic accept_latch;
    logic overrun_flag;

    // Input stage: one register on the pixel stream ahead of the accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en_r <= 1'b0;
            mask_r   <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
        end else begin
            pix_en_r <= pix_en;
            mask_r   <= mask;
            x_r      <= tv_x;
            y_r      <= tv_y;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next state: FLUSH lets the last in-flight pixel land before
    // the totals are latched; a new frame_start during FLUSH flushes again
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SYNC: if (frame_start) state_next = ACCUM;
            ACCUM:     if (frame_start) state_next = FLUSH;
            FLUSH:     state_next = frame_start ? FLUSH : ACCUM;
            default:   state_next = WAIT_SYNC;
        endcase
    end

    assign count_en     = pix_en_r && mask_r && (state != WAIT_SYNC);
    assign latch        = (state == FLUSH);
    assign accept_latch = latch && !(stat_valid && !stat_ready);

    // Next accumulator values; FLUSH restarts from the empty frame so the
    // pixel registered alongside frame_start is counted in the new frame
    always_comb begin
        base_area  = '0;
        base_x_min = MIN_INIT;
        base_x_max = MAX_INIT;
        base_y_min = MIN_INIT;
        base_y_max = MAX_INIT;
        if (state == ACCUM) begin
            base_area  = area_acc;
            base_x_min = x_min_acc;
            base_x_max = x_max_acc;
            base_y_min = y_min_acc;
            base_y_max = y_max_acc;
        end
        area_nxt  = base_area;
        x_min_nxt = base_x_min;
        x_max_nxt = base_x_max;
        y_min_nxt = base_y_min;
        y_max_nxt = base_y_max;
        if (count_en) begin
            if (base_area != '1) begin
                area_nxt = base_area + AREA_W'(1);
            end
            if (x_r < base_x_min) x_min_nxt = x_r;
            if (x_r > base_x_max) x_max_nxt = x_r;
            if (y_r < base_y_min) y_min_nxt = y_r;
            if (y_r > base_y_max) y_max_nxt = y_r;
        end
    end

    // Area and bounding-box accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            area_acc  <= '0;
            x_min_acc <= MIN_INIT;
            x_max_acc <= MAX_INIT;
            y_min_acc <= MIN_INIT;
            y_max_acc <= MAX_INIT;
        end else begin
            area_acc  <= area_nxt;
            x_min_acc <= x_min_nxt;
            x_max_acc <= x_max_nxt;
            y_min_acc <= y_min_nxt;
            y_max_acc <= y_max_nxt;
        end
    end

    // Result handshake: a result arriving while the previous one is still
    // unaccepted is dropped and remembered for the next delivered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_valid   <= 1'b0;
            overrun_flag <= 1'b0;
        end else if (latch) begin
            if (stat_valid && !stat_ready) begin
                overrun_flag <= 1'b1;
            end else begin
                stat_valid   <= 1'b1;
                overrun_flag <= 1'b0;
            end
        end else if (stat_valid && stat_ready) begin
            stat_valid <= 1'b0;
        end
    end

    // Result data registers, held stable until the next accepted latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_area    <= '0;
            stat_x_min   <= '0;
            stat_x_max   <= '0;
            stat_y_min   <= '0;
            stat_y_max   <= '0;
            stat_empty   <= 1'b0;
            stat_overrun <= 1'b0;
        end else if (accept_latch) begin
            stat_area    <= area_acc;
            stat_x_min   <= x_min_acc;
            stat_x_max   <= x_max_acc;
            stat_y_min   <= y_min_acc;
            stat_y_max   <= y_max_acc;
            stat_empty   <= (area_acc == '0);
            stat_overrun <= overrun_flag;
        end
    end

`ifdef MASK_FRAME_STATS_RUNS_EN
    logic             run_start;
    logic [RUN_W-1:0] runs_acc;
    logic [RUN_W-1:0] runs_nxt;
    logic [RUN_W-1:0] base_runs;

    mask_run_detector #(
        .X_W (X_W)
    ) u_run_detector (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_clear  (state == WAIT_SYNC),
        .frame_first (state == FLUSH),
        .pix_en      (pix_en_r && (state != WAIT_SYNC)),
        .mask        (mask_r),
        .tv_x        (x_r),
        .tv_y        (y_r),
        .run_start   (run_start)
    );

    // Next run count, restarting from zero on the same terms as the area
    always_comb begin
        base_runs = (state == ACCUM) ? runs_acc : '0;
        runs_nxt  = base_runs;
        if (run_start && (base_runs != '1)) begin
            runs_nxt = base_runs + RUN_W'(1);
        end
    end

    // Run counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runs_acc <= '0;
        end else begin
            runs_acc <= runs_nxt;
        end
    end

    // Run count result register, loaded with the other result fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_runs <= '0;
        end else if (accept_latch) begin
            stat_runs <= runs_acc;
        end
    end
`else
    assign stat_runs = '0;
`endif

endmodule

// File: tb/tb_mask_frame_stats.sv
// Self-checking bench for mask_frame_stats: a frame-level reference model
// (pixel lists per frame, stats computed by plain arithmetic at frame end)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mask_frame_stats;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       m;
    } pix_t;

    typedef struct {
        logic [31:0] area;
        logic [31:0] x_min;
        logic [31:0] x_max;
        logic [31:0] y_min;
        logic [31:0] y_max;
        logic [31:0] runs;
        logic [31:0] empty;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        mask = 1'b0;
    logic [9:0]  tv_x = '0;
    logic [9:0]  tv_y = '0;
    logic        stat_ready = 1'b1;
    logic        stat_valid;
    logic [19:0] stat_area;
    logic [9:0]  stat_x_min;
    logic [9:0]  stat_x_max;
    logic [9:0]  stat_y_min;
    logic [9:0]  stat_y_max;
    logic [15:0] stat_runs;
    logic        stat_empty;
    logic        stat_overrun;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_ready = 1'b0;

    // model state
    bit   synced = 1'b0;
    pix_t frame_q[$];
    bit   pend = 1'b0;
    res_t pend_res;
    bit   m_valid = 1'b0;
    res_t m_res;
    bit   m_ovr = 1'b0;
    bit   ovr_flag = 1'b0;

    always #5 clk = ~clk;

    mask_frame_stats dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .frame_start  (frame_start),
        .mask         (mask),
        .tv_x         (tv_x),
        .tv_y         (tv_y),
        .stat_valid   (stat_valid),
        .stat_ready   (stat_ready),
        .stat_area    (stat_area),
        .stat_x_min   (stat_x_min),
        .stat_x_max   (stat_x_max),
        .stat_y_min   (stat_y_min),
        .stat_y_max   (stat_y_max),
        .stat_runs    (stat_runs),
        .stat_empty   (stat_empty),
        .stat_overrun (stat_overrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; they are sampled at the next rising edge
    task automatic applyStimulus(input logic fs, input logic pe, input logic m,
                                 input logic [9:0] x, input logic [9:0] y);
        frame_start = fs;
        pix_en      = pe;
        mask        = m;
        tv_x        = x;
        tv_y        = y;
        if (rand_ready) stat_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic line(input int y, input int x0, input int n, input logic [15:0] pattern);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, pattern[i], 10'(x0 + i), 10'(y));
    endtask

    // Frame statistics straight from the definition over the pixel list
    function automatic res_t compute_stats();
        res_t r;
        int area = 0;
        int runs = 0;
        r.x_min = 1023; r.x_max = 0; r.y_min = 1023; r.y_max = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (frame_q[i].m) begin
                area++;
                if (32'(frame_q[i].x) < r.x_min) r.x_min = 32'(frame_q[i].x);
                if (32'(frame_q[i].x) > r.x_max) r.x_max = 32'(frame_q[i].x);
                if (32'(frame_q[i].y) < r.y_min) r.y_min = 32'(frame_q[i].y);
                if (32'(frame_q[i].y) > r.y_max) r.y_max = 32'(frame_q[i].y);
                if (i == 0 || !frame_q[i-1].m || frame_q[i-1].y != frame_q[i].y || frame_q[i].x == 10'd0)
                    runs++;
            end
        end
        r.area  = (area > 1048575) ? 32'd1048575 : 32'(area);
        r.empty = (area == 0) ? 32'd1 : 32'd0;
`ifdef MASK_FRAME_STATS_RUNS_EN
        r.runs = (runs > 65535) ? 32'd65535 : 32'(runs);
`else
        r.runs = (runs < 0) ? 32'd1 : 32'd0;
`endif
        return r;
    endfunction

    // Transaction-level reference: frame lists, result one edge after frame end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced = 1'b0; frame_q.delete(); pend = 1'b0;
            m_valid = 1'b0; m_ovr = 1'b0; ovr_flag = 1'b0;
        end else begin
            if (pend) begin
                if (m_valid && !stat_ready) ovr_flag = 1'b1;
                else begin
                    m_res = pend_res; m_ovr = ovr_flag; ovr_flag = 1'b0; m_valid = 1'b1;
                end
                pend = 1'b0;
            end else if (m_valid && stat_ready) begin
                m_valid = 1'b0;
            end
            if (frame_start) begin
                if (synced) begin
                    pend = 1'b1;
                    pend_res = compute_stats();
                end
                synced = 1'b1;
                frame_q.delete();
            end
            if (pix_en && synced) frame_q.push_back('{x: tv_x, y: tv_y, m: mask});
        end
    end

    // Cycle compare against the model on the falling edge
    always @(negedge clk) begin
        checkOutput("cmp_valid", 32'(stat_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("cmp_area",    32'(stat_area),    m_res.area);
            checkOutput("cmp_x_min",   32'(stat_x_min),   m_res.x_min);
            checkOutput("cmp_x_max",   32'(stat_x_max),   m_res.x_max);
            checkOutput("cmp_y_min",   32'(stat_y_min),   m_res.y_min);
            checkOutput("cmp_y_max",   32'(stat_y_max),   m_res.y_max);
            checkOutput("cmp_runs",    32'(stat_runs),    m_res.runs);
            checkOutput("cmp_empty",   32'(stat_empty),   m_res.empty);
            checkOutput("cmp_overrun", 32'(stat_overrun), 32'(m_ovr));
        end
    end

    initial begin
        logic [31:0] exp_runs3;
`ifdef MASK_FRAME_STATS_RUNS_EN
        exp_runs3 = 32'd3;
`else
        exp_runs3 = 32'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(stat_valid), 32'd0);
        checkOutput("reset_area", 32'(stat_area), 32'd0);
        checkOutput("reset_x_min", 32'(stat_x_min), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 4x3 block at x=100..103, y=50..52
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        for (int y = 50; y <= 52; y++) line(y, 98, 8, 16'b0000_0000_0011_1100);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        checkOutput("s1_valid_early", 32'(stat_valid), 32'd0);
        idle(1);
        checkOutput("s1_valid", 32'(stat_valid), 32'd1);
        checkOutput("s1_area", 32'(stat_area), 32'd12);
        checkOutput("s1_x_min", 32'(stat_x_min), 32'd100);
        checkOutput("s1_x_max", 32'(stat_x_max), 32'd103);
        checkOutput("s1_y_min", 32'(stat_y_min), 32'd50);
        checkOutput("s1_y_max", 32'(stat_y_max), 32'd52);
        checkOutput("s1_runs", 32'(stat_runs), exp_runs3);
        checkOutput("s1_empty", 32'(stat_empty), 32'd0);

        // all-zero frame
        line(60, 0, 8, 16'h0000);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s2_area", 32'(stat_area), 32'd0);
        checkOutput("s2_empty", 32'(stat_empty), 32'd1);
        checkOutput("s2_x_min", 32'(stat_x_min), 32'd1023);
        checkOutput("s2_x_max", 32'(stat_x_max), 32'd0);
        checkOutput("s2_runs", 32'(stat_runs), 32'd0);

        // run across line end and line start
        line(9, 0, 8, 16'b0000_0000_1100_0000);
        line(10, 0, 4, 16'b0000_0000_0000_1011);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s3_area", 32'(stat_area), 32'd5);
        checkOutput("s3_runs", 32'(stat_runs), exp_runs3);
        idle(1);

        // overrun: hold ready low across two frame ends
        stat_ready = 1'b0;
        line(20, 5, 3, 16'b0000_0000_0000_0101);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s4_a_area", 32'(stat_area), 32'd2);
        line(21, 0, 5, 16'b0000_0000_0001_1111);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s4_hold_valid", 32'(stat_valid), 32'd1);
        checkOutput("s4_hold_area", 32'(stat_area), 32'd2);
        stat_ready = 1'b1;
        line(22, 3, 1, 16'h0001);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s4_c_area", 32'(stat_area), 32'd1);
        checkOutput("s4_c_overrun", 32'(stat_overrun), 32'd1);
        line(23, 1, 3, 16'h0007);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s4_d_area", 32'(stat_area), 32'd3);
        checkOutput("s4_d_overrun", 32'(stat_overrun), 32'd0);

        // reset mid-frame with a result still pending
        stat_ready = 1'b0;
        line(24, 0, 4, 16'h000F);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_valid", 32'(stat_valid), 32'd0);
        checkOutput("s5_rst_area", 32'(stat_area), 32'd0);
        checkOutput("s5_rst_y_min", 32'(stat_y_min), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stat_ready = 1'b1;
        line(25, 0, 3, 16'h0007);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s5_no_result", 32'(stat_valid), 32'd0);
        line(30, 0, 2, 16'h0003);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(1);
        checkOutput("s5_resume_valid", 32'(stat_valid), 32'd1);
        checkOutput("s5_resume_area", 32'(stat_area), 32'd2);

        // closely spaced frame_start pulses, no pixels
        idle(2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
        idle(4);

        // randomized frames with random back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int lines = $urandom_range(1, 4);
            int w     = $urandom_range(1, 16);
            int bx    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1024 - w);
            int by    = $urandom_range(0, 1020);
            for (int l = 0; l < lines; l++) begin
                for (int i = 0; i < w; i++) begin
                    applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                  10'(bx + i), 10'(by + l));
                end
            end
            idle($urandom_range(2, 4));
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          10'(bx), 10'(by));
        end
        rand_ready = 1'b0;
        stat_ready = 1'b1;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
